// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared state, redirect-source and default-vector constants for pc_sequencer
// PC_BOUND_CHECK_EN adds the default fetch limit.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    HALT  = 2'd3
  } pc_state_e;

  localparam logic [1:0] SRC_SEQ  = 2'd0;
  localparam logic [1:0] SRC_BR   = 2'd1;
  localparam logic [1:0] SRC_JMP  = 2'd2;
  localparam logic [1:0] SRC_TRAP = 2'd3;

  localparam logic [31:0] DEF_RESET_VEC    = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VEC     = 32'h0000_0040;
  localparam int          DEF_FLUSH_CYCLES = 2;
  localparam int          FLUSH_CNT_W      = 3;
`ifdef PC_BOUND_CHECK_EN
  localparam logic [31:0] DEF_PC_LIMIT     = 32'h0000_FFFF;
`endif

endpackage

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - request bundle from the control unit and fetch status back to it
// PC_BOUND_CHECK_EN adds bound_err.
interface pc_sequencer_if #(parameter int WIDTH = 32);

  logic             stall;
  logic             branch_req;
  logic [WIDTH-1:0] branch_target;
  logic             jump_req;
  logic [WIDTH-1:0] jump_target;
  logic             trap_req;
  logic             halt_req;
  logic             resume;
  logic [WIDTH-1:0] pc;
  logic             pc_valid;
  logic             flush;
  logic [1:0]       redirect_src;
  logic             halted;

`ifdef PC_BOUND_CHECK_EN
  logic             bound_err;

  modport master (
    output stall, branch_req, branch_target, jump_req, jump_target, trap_req, halt_req, resume,
    input  pc, pc_valid, flush, redirect_src, halted, bound_err
  );
  modport slave (
    input  stall, branch_req, branch_target, jump_req, jump_target, trap_req, halt_req, resume,
    output pc, pc_valid, flush, redirect_src, halted, bound_err
  );
`else
  modport master (
    output stall, branch_req, branch_target, jump_req, jump_target, trap_req, halt_req, resume,
    input  pc, pc_valid, flush, redirect_src, halted
  );
  modport slave (
    input  stall, branch_req, branch_target, jump_req, jump_target, trap_req, halt_req, resume,
    output pc, pc_valid, flush, redirect_src, halted
  );
`endif

endinterface

// File: rtl/pc_incr.sv
// rtl/pc_incr.sv - combinational sequential-path incrementer, wraps modulo 2^WIDTH
module pc_incr #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] pc_i,
  output logic [WIDTH-1:0] pc_inc_o
);

  assign pc_inc_o = pc_i + WIDTH'(1);

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter owner: boot, sequential advance, redirects, flush bubbles, halt
// PC_BOUND_CHECK_EN turns out-of-range next-PCs into traps and adds bound_err.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VEC    = WIDTH'(DEF_RESET_VEC),
  parameter logic [WIDTH-1:0] TRAP_VEC     = WIDTH'(DEF_TRAP_VEC),
  parameter int               FLUSH_CYCLES = DEF_FLUSH_CYCLES
`ifdef PC_BOUND_CHECK_EN
  , parameter logic [WIDTH-1:0] PC_LIMIT   = WIDTH'(DEF_PC_LIMIT)
`endif
) (
  input  logic           clk,
  input  logic           rst_n,
  pc_sequencer_if.slave  ctrl_if
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_INIT = FLUSH_CNT_W'(FLUSH_CYCLES);

  pc_state_e              state_q, state_d;
  logic [WIDTH-1:0]       pc_q, pc_d, pc_inc;
  logic                   valid_q, valid_d;
  logic                   flush_q, flush_d;
  logic                   halted_q, halted_d;
  logic [1:0]             src_q, src_d;
  logic [FLUSH_CNT_W-1:0] cnt_q, cnt_d;
  logic                   load_en, redir;
  logic [WIDTH-1:0]       load_pc;
  logic [1:0]             load_src;
`ifdef PC_BOUND_CHECK_EN
  logic                   berr_q, berr_d;
`endif

  pc_incr #(.WIDTH(WIDTH)) u_incr (
    .pc_i     (pc_q),
    .pc_inc_o (pc_inc)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    valid_d  = valid_q;
    flush_d  = 1'b0;
    halted_d = halted_q;
    src_d    = src_q;
    cnt_d    = cnt_q;
    load_en  = 1'b0;
    redir    = 1'b0;
    load_pc  = pc_inc;
    load_src = SRC_SEQ;
`ifdef PC_BOUND_CHECK_EN
    berr_d   = 1'b0;
`endif

    case (state_q)
      BOOT: begin
        state_d = RUN;
        valid_d = 1'b1;
      end
      RUN: begin
        valid_d = 1'b1;
        if (ctrl_if.trap_req) begin
          load_en = 1'b1; redir = 1'b1; load_pc = TRAP_VEC; load_src = SRC_TRAP;
        end else if (ctrl_if.halt_req) begin
          state_d = HALT; valid_d = 1'b0; halted_d = 1'b1;
        end else if (ctrl_if.jump_req) begin
          load_en = 1'b1; redir = 1'b1; load_pc = ctrl_if.jump_target; load_src = SRC_JMP;
        end else if (ctrl_if.branch_req) begin
          load_en = 1'b1; redir = 1'b1; load_pc = ctrl_if.branch_target; load_src = SRC_BR;
        end else if (!ctrl_if.stall) begin
          load_en = 1'b1;
        end
      end
      FLUSH: begin
        flush_d = 1'b1;
        valid_d = 1'b0;
        // A trap here restarts the bubble window from the full count.
        if (ctrl_if.trap_req) begin
          load_en = 1'b1; load_pc = TRAP_VEC; load_src = SRC_TRAP; cnt_d = FLUSH_INIT;
        end else if (cnt_q <= FLUSH_CNT_W'(1)) begin
          state_d = RUN; valid_d = 1'b1; flush_d = 1'b0; cnt_d = '0;
        end else begin
          cnt_d = cnt_q - FLUSH_CNT_W'(1);
        end
      end
      HALT: begin
        valid_d = 1'b0;
        if (ctrl_if.trap_req) begin
          load_en = 1'b1; redir = 1'b1; load_pc = TRAP_VEC; load_src = SRC_TRAP; halted_d = 1'b0;
        end else if (ctrl_if.resume) begin
          state_d = RUN; valid_d = 1'b1; halted_d = 1'b0;
        end
      end
    endcase

`ifdef PC_BOUND_CHECK_EN
    if (state_q == RUN && load_en && load_src != SRC_TRAP && load_pc > PC_LIMIT) begin
      load_pc = TRAP_VEC; load_src = SRC_TRAP; redir = 1'b1; berr_d = 1'b1;
    end
`endif

    if (load_en) begin
      pc_d  = load_pc;
      src_d = load_src;
    end

    // With no bubbles the target is fetched immediately and flush is a single pulse.
    if (redir) begin
      flush_d = 1'b1;
      if (FLUSH_CYCLES > 0) begin
        state_d = FLUSH; cnt_d = FLUSH_INIT; valid_d = 1'b0;
      end else begin
        state_d = RUN; valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= BOOT;
      pc_q     <= RESET_VEC;
      valid_q  <= 1'b0;
      flush_q  <= 1'b0;
      halted_q <= 1'b0;
      src_q    <= SRC_SEQ;
      cnt_q    <= '0;
`ifdef PC_BOUND_CHECK_EN
      berr_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      flush_q  <= flush_d;
      halted_q <= halted_d;
      src_q    <= src_d;
      cnt_q    <= cnt_d;
`ifdef PC_BOUND_CHECK_EN
      berr_q   <= berr_d;
`endif
    end
  end

  assign ctrl_if.pc           = pc_q;
  assign ctrl_if.pc_valid     = valid_q;
  assign ctrl_if.flush        = flush_q;
  assign ctrl_if.redirect_src = src_q;
  assign ctrl_if.halted       = halted_q;
`ifdef PC_BOUND_CHECK_EN
  assign ctrl_if.bound_err    = berr_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed and random bench for pc_sequencer against a cycle-level reference model
// PC_BOUND_CHECK_EN selects the bounded build with PC_LIMIT=0xFF.
module tb_pc_sequencer;

  localparam logic [31:0] RVEC = 32'h0000_0000;
  localparam logic [31:0] TVEC = 32'h0000_0040;
  localparam int          FC   = 2;
`ifdef PC_BOUND_CHECK_EN
  localparam logic [31:0] LIMIT = 32'h0000_00FF;
  localparam logic [31:0] TMASK = 32'h0000_01FF;
`else
  localparam logic [31:0] TMASK = 32'hFFFF_FFFF;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  pc_sequencer_if #(.WIDTH(32)) bus ();

  pc_sequencer #(
    .WIDTH        (32),
    .RESET_VEC    (RVEC),
    .TRAP_VEC     (TVEC),
    .FLUSH_CYCLES (FC)
`ifdef PC_BOUND_CHECK_EN
    , .PC_LIMIT   (LIMIT)
`endif
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ctrl_if (bus)
  );

  always #5 clk = ~clk;

  // Reference model: fetch address, outstanding bubble count and mode flags.
  logic [31:0] m_pc;
  logic        m_valid, m_flush, m_halted, m_boot, m_berr;
  logic [1:0]  m_src;
  int          m_bubbles;

  function automatic void m_redirect(input logic [31:0] t, input logic [1:0] s);
    m_pc    = t;
    m_src   = s;
    m_flush = 1'b1;
    if (FC > 0) begin
      m_bubbles = FC;
      m_valid   = 1'b0;
    end else begin
      m_valid   = 1'b1;
    end
  endfunction

  function automatic void m_load(input logic [31:0] t, input logic [1:0] s, input bit is_redirect);
`ifdef PC_BOUND_CHECK_EN
    if (t > LIMIT) begin
      m_redirect(TVEC, 2'd3);
      m_berr = 1'b1;
      return;
    end
`endif
    if (is_redirect) m_redirect(t, s);
    else begin
      m_pc  = t;
      m_src = s;
    end
  endfunction

  function automatic void model_edge();
    longint nxt;
    m_berr = 1'b0;
    if (!rst_n) begin
      m_pc = RVEC; m_valid = 0; m_flush = 0; m_src = 0; m_halted = 0; m_boot = 1; m_bubbles = 0;
    end else if (m_boot) begin
      m_boot = 0; m_valid = 1; m_flush = 0;
    end else if (m_halted) begin
      if (bus.trap_req) begin
        m_halted = 0;
        m_redirect(TVEC, 2'd3);
      end else if (bus.resume) begin
        m_halted = 0;
        m_valid  = 1;
      end
    end else if (m_bubbles > 0) begin
      if (bus.trap_req) begin
        m_pc = TVEC; m_src = 2'd3; m_bubbles = FC;
      end else begin
        m_bubbles = m_bubbles - 1;
        if (m_bubbles == 0) begin
          m_valid = 1; m_flush = 0;
        end
      end
    end else begin
      m_flush = 0;
      if (bus.trap_req) m_redirect(TVEC, 2'd3);
      else if (bus.halt_req) begin
        m_halted = 1; m_valid = 0;
      end
      else if (bus.jump_req)   m_load(bus.jump_target, 2'd2, 1'b1);
      else if (bus.branch_req) m_load(bus.branch_target, 2'd1, 1'b1);
      else if (!bus.stall) begin
        nxt = (longint'(m_pc) + 1) % 64'h1_0000_0000;
        m_load(32'(nxt), 2'd0, 1'b0);
      end
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic compare_model();
    check("pc", bus.pc, m_pc);
    check("pc_valid", 32'(bus.pc_valid), 32'(m_valid));
    check("flush", 32'(bus.flush), 32'(m_flush));
    check("redirect_src", 32'(bus.redirect_src), 32'(m_src));
    check("halted", 32'(bus.halted), 32'(m_halted));
`ifdef PC_BOUND_CHECK_EN
    check("bound_err", 32'(bus.bound_err), 32'(m_berr));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_model();
  endtask

  task automatic clear_req();
    bus.stall = 0; bus.branch_req = 0; bus.jump_req = 0; bus.trap_req = 0;
    bus.halt_req = 0; bus.resume = 0;
  endtask

  task automatic expect_fetch(input string tag, input logic [31:0] pc, input logic valid, input logic flush);
    check({tag, "_pc"}, bus.pc, pc);
    check({tag, "_valid"}, 32'(bus.pc_valid), 32'(valid));
    check({tag, "_flush"}, 32'(bus.flush), 32'(flush));
  endtask

  initial begin
    rst_n = 1'b0;
    clear_req();
    bus.branch_target = '0;
    bus.jump_target   = '0;
    tick();
    tick();
    expect_fetch("reset", RVEC, 1'b0, 1'b0);
    check("reset_src", 32'(bus.redirect_src), 32'd0);
    check("reset_halted", 32'(bus.halted), 32'd0);

    // Boot then sequential fetch 0,1,2,3
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      expect_fetch("seq", 32'(i), 1'b1, 1'b0);
      if (i < 3) tick();
    end
    tick();
    tick();
    check("pre_branch_pc", bus.pc, 32'h5);

    // Branch with two bubble cycles
    bus.branch_req = 1; bus.branch_target = 32'h20;
    tick();
    clear_req();
    expect_fetch("br_b1", 32'h20, 1'b0, 1'b1);
    check("br_src", 32'(bus.redirect_src), 32'd1);
    tick();
    expect_fetch("br_b2", 32'h20, 1'b0, 1'b1);
    tick();
    expect_fetch("br_tgt", 32'h20, 1'b1, 1'b0);
    tick();
    expect_fetch("br_next", 32'h21, 1'b1, 1'b0);

    // Trap wins over jump and stall; jump ignored in FLUSH; trap in FLUSH restarts
    bus.trap_req = 1; bus.jump_req = 1; bus.stall = 1; bus.jump_target = 32'h80;
    tick();
    clear_req();
    expect_fetch("trap", TVEC, 1'b0, 1'b1);
    check("trap_src", 32'(bus.redirect_src), 32'd3);
    bus.jump_req = 1;
    tick();
    clear_req();
    expect_fetch("fl_jump", TVEC, 1'b0, 1'b1);
    bus.trap_req = 1;
    tick();
    clear_req();
    tick();
    expect_fetch("fl_retrap", TVEC, 1'b0, 1'b1);
    tick();
    expect_fetch("fl_done", TVEC, 1'b1, 1'b0);

`ifndef PC_BOUND_CHECK_EN
    // Wrap from all-ones to zero
    bus.jump_req = 1; bus.jump_target = 32'hFFFF_FFFF;
    tick();
    clear_req();
    tick();
    tick();
    expect_fetch("wrap_top", 32'hFFFF_FFFF, 1'b1, 1'b0);
    tick();
    expect_fetch("wrap_zero", 32'h0, 1'b1, 1'b0);
`endif

    // Halt at 0x10, hold, resume
    bus.jump_req = 1; bus.jump_target = 32'h10;
    tick();
    clear_req();
    tick();
    tick();
    bus.halt_req = 1;
    tick();
    clear_req();
    for (int i = 0; i < 5; i++) begin
      expect_fetch("halt_hold", 32'h10, 1'b0, 1'b0);
      check("halt_flag", 32'(bus.halted), 32'd1);
      tick();
    end
    bus.resume = 1;
    tick();
    clear_req();
    expect_fetch("resume", 32'h10, 1'b1, 1'b0);
    check("resume_halted", 32'(bus.halted), 32'd0);
    tick();
    expect_fetch("resume_next", 32'h11, 1'b1, 1'b0);

    // Reset in the middle of a flush
    bus.branch_req = 1; bus.branch_target = 32'h33;
    tick();
    clear_req();
    rst_n = 1'b0;
    tick();
    expect_fetch("rst_flush", RVEC, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    expect_fetch("rst_boot", RVEC, 1'b1, 1'b0);

`ifdef PC_BOUND_CHECK_EN
    bus.jump_req = 1; bus.jump_target = 32'h100;
    tick();
    clear_req();
    check("bnd_jump_pc", bus.pc, TVEC);
    check("bnd_jump_src", 32'(bus.redirect_src), 32'd3);
    check("bnd_jump_err", 32'(bus.bound_err), 32'd1);
    tick();
    check("bnd_err_pulse", 32'(bus.bound_err), 32'd0);
    tick();
    bus.jump_req = 1; bus.jump_target = 32'hFF;
    tick();
    clear_req();
    tick();
    tick();
    expect_fetch("bnd_edge", 32'hFF, 1'b1, 1'b0);
    tick();
    check("bnd_seq_pc", bus.pc, TVEC);
    check("bnd_seq_err", 32'(bus.bound_err), 32'd1);
`endif

    // Random requests against the model
    for (int i = 0; i < 600; i++) begin
      rst_n             = ($urandom_range(0, 99) >= 1);
      bus.trap_req      = ($urandom_range(0, 99) < 4);
      bus.halt_req      = ($urandom_range(0, 99) < 4);
      bus.resume        = ($urandom_range(0, 99) < 30);
      bus.jump_req      = ($urandom_range(0, 99) < 8);
      bus.branch_req    = ($urandom_range(0, 99) < 10);
      bus.stall         = ($urandom_range(0, 99) < 25);
      bus.jump_target   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFE : ($urandom & TMASK);
      bus.branch_target = $urandom & TMASK;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the program counter register and decides the next PC each cycle.
- Selects between the sequential PC+1 path and the trap, jump and branch redirect requesters.
- Sequences boot, stall, pipeline-flush bubbles after a redirect, and halt/resume.
- Sits between the control unit and instruction memory. It replaces the free-standing PC register plus incrementer in the fetch stage.

Parameters:
- WIDTH, 32: PC width in bits; PC is a word address.
- RESET_VEC, 32'h0000_0000: first fetch address after reset.
- TRAP_VEC, 32'h0000_0040: target loaded on trap_req.
- FLUSH_CYCLES, 2: bubble cycles after any redirect; legal range 0..7.
- PC_LIMIT, 32'h0000_FFFF: highest legal fetch address (used only with the optional feature).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  synchronous active-low reset.
- stall  in  1  hold the sequential advance (data hazard / memory wait).
- branch_req  in  1  taken conditional branch this cycle.
- branch_target  in  WIDTH  branch destination.
- jump_req  in  1  unconditional jump this cycle.
- jump_target  in  WIDTH  jump destination.
- trap_req  in  1  exception / trap request.
- halt_req  in  1  stop fetching.
- resume  in  1  leave HALT.
- pc  out  WIDTH  current fetch address.
- pc_valid  out  1  pc is a real fetch this cycle.
- flush  out  1  kill younger in-flight instructions.
- redirect_src  out  2  source of the last PC load: 0=seq, 1=branch, 2=jump, 3=trap.
- halted  out  1  block is in HALT.

Behaviour:
- Interface: one clock; reset is synchronous and active-low. Port names are clk and rst_n.
- Reset (rst_n=0 at a rising edge):
  - pc=RESET_VEC, pc_valid=0, flush=0, redirect_src=0, halted=0.
  - state=BOOT, flush counter=0.
  - Reset overrides everything, in any state, including mid-FLUSH.
- States: BOOT, RUN, FLUSH, HALT.
- BOOT: lasts exactly one cycle, then RUN. First valid fetch is RESET_VEC, the cycle after reset deasserts. Requests in BOOT are ignored.
- RUN: pc_valid=1. Request priority, evaluated each cycle:
  - trap_req: pc<=TRAP_VEC, src=3.
  - halt_req: pc held, go HALT.
  - jump_req: pc<=jump_target, src=2.
  - branch_req: pc<=branch_target, src=1.
  - stall: pc held, pc_valid stays 1, src unchanged.
  - Otherwise: pc<=pc+1, src=0.
- Redirects beat stall: a redirect taken while stall=1 is still loaded.
- Redirect (trap, jump or branch):
  - If FLUSH_CYCLES>0: go FLUSH, flush counter<=FLUSH_CYCLES.
  - If FLUSH_CYCLES=0: stay RUN; flush pulses for one cycle; the target is fetched next cycle.
- FLUSH:
  - flush=1 and pc_valid=0; pc holds the target; counter decrements each cycle.
  - When the counter reaches 0: go RUN, fetch the target (pc_valid=1), flush=0.
  - Only trap_req is honoured in FLUSH: pc<=TRAP_VEC, counter reloads to FLUSH_CYCLES.
  - jump, branch, halt and stall are ignored in FLUSH.
- HALT:
  - pc held, pc_valid=0, halted=1.
  - resume: go RUN next cycle; same pc refetched with pc_valid=1.
  - trap_req in HALT: load TRAP_VEC and go FLUSH. Trap has priority over resume.
- Arithmetic: pc+1 is modulo 2^WIDTH. 32'hFFFF_FFFF advances to 0 with no error.
- Targets: taken unchanged, no alignment check.
- Outputs are registered. No combinational path from inputs to pc or pc_valid.
- Redirect latency: request at edge N gives the target on pc after edge N; first valid fetch of the target after edge N+FLUSH_CYCLES.

Optional Feature:
- Macro: PC_BOUND_CHECK_EN.
- Defined:
  - Any next-PC (sequential or target) greater than PC_LIMIT is replaced by TRAP_VEC with src=3.
  - This is treated as a trap, including the FLUSH entry.
  - Adds output bound_err (1 bit), a one-cycle pulse on the substituted load; reset value 0.
- Undefined: no check, no bound_err port; PC_LIMIT is unused.

Decomposition:
- Package pc_seq_pkg holds:
  - state enum: BOOT, RUN, FLUSH, HALT.
  - redirect_src encoding constants: SRC_SEQ, SRC_BR, SRC_JMP, SRC_TRAP.
  - default vector constants.
- One natural sub-module: pc_incr, a combinational WIDTH-bit +1 with wrap, instantiated for the sequential path.

Test Plan:
- Reset release, no requests, RESET_VEC=0:
  - Cycle 1: BOOT, pc_valid=0.
  - Following cycles: pc=0,1,2,3 with pc_valid=1, src=0.
- At pc=5, branch_req=1, branch_target=0x20, FLUSH_CYCLES=2:
  - flush=1 and pc_valid=0 for 2 cycles, pc=0x20, src=1.
  - Then pc=0x20 valid, then 0x21.
- Same cycle trap_req, jump_req and stall with jump_target=0x80:
  - pc=0x40, src=3.
  - Also: a jump during FLUSH is ignored; a trap during FLUSH restarts the 2-cycle flush.
- pc=0xFFFF_FFFF, no requests (bound check off) -> next pc=0, valid.
- halt_req at pc=0x10:
  - halted=1, pc=0x10, pc_valid=0 held 5 cycles.
  - resume -> pc=0x10 valid, then 0x11.
  - Separately: rst_n=0 mid-FLUSH -> BOOT, pc=RESET_VEC, flush=0 next cycle.
- PC_BOUND_CHECK_EN, PC_LIMIT=0xFF:
  - jump_target=0x100 -> pc=0x40, src=3, bound_err pulse.
  - Sequential 0xFF -> 0x40 with bound_err pulse.
